// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the register-transfer bus arbiter.
//   SEL_W          : width of a bus source/destination code
//   SRC_NONE..AC   : bus source codes (0 = bus idle, reads 0)
//   state_t        : arbiter FSM state encoding
//   transfer_legal : legality of a (source, destination) pair
package bus_arbiter_pkg;

   localparam int SEL_W = 5;

   localparam logic [SEL_W-1:0] SRC_NONE = 5'd0;
   localparam logic [SEL_W-1:0] SRC_IM   = 5'd1;
   localparam logic [SEL_W-1:0] SRC_DM   = 5'd2;
   localparam logic [SEL_W-1:0] SRC_IR   = 5'd3;
   localparam logic [SEL_W-1:0] SRC_PC   = 5'd4;
   localparam logic [SEL_W-1:0] SRC_TAC  = 5'd5;
   localparam logic [SEL_W-1:0] SRC_R    = 5'd6;
   localparam logic [SEL_W-1:0] SRC_CI   = 5'd7;
   localparam logic [SEL_W-1:0] SRC_CJ   = 5'd8;
   localparam logic [SEL_W-1:0] SRC_CK   = 5'd9;
   localparam logic [SEL_W-1:0] SRC_AA   = 5'd10;
   localparam logic [SEL_W-1:0] SRC_AB   = 5'd11;
   localparam logic [SEL_W-1:0] SRC_AD   = 5'd12;
   localparam logic [SEL_W-1:0] SRC_SI   = 5'd13;
   localparam logic [SEL_W-1:0] SRC_SJ   = 5'd14;
   localparam logic [SEL_W-1:0] SRC_SK   = 5'd15;
   localparam logic [SEL_W-1:0] SRC_AC   = 5'd16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SRC   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   // A transfer needs a real source (1..16) and a destination in 1..dst_max.
   function automatic logic transfer_legal(input logic [SEL_W-1:0] src,
                                           input logic [SEL_W-1:0] dst,
                                           input logic [SEL_W-1:0] dst_max);
      return (src != SRC_NONE) && (src <= SRC_AC) &&
             (dst != '0) && (dst <= dst_max);
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester/bus-side signal bundle of the bus arbiter.
//   req      : per-requester level request
//   src_sel  : per-requester source code, requester i at [5i+4:5i]
//   dst_sel  : per-requester destination code, same packing
//   read     : bus mux select (0 = idle)
//   write_en : one-hot destination load strobe
//   grant    : one-hot owner, grant until ack
//   ack      : one-cycle completion pulse to the owner
//   err      : pulses with ack for an illegal transfer
//   busy     : arbiter not idle
// Modports: master = requester/bus side, slave = arbiter.
interface bus_arbiter_if
   import bus_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int NDST = 16
) ();

   logic [NREQ-1:0]       req;
   logic [SEL_W*NREQ-1:0] src_sel;
   logic [SEL_W*NREQ-1:0] dst_sel;
   logic [SEL_W-1:0]      read;
   logic [NDST-1:0]       write_en;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       ack;
   logic                  err;
   logic                  busy;

   modport master (
      output req, src_sel, dst_sel,
      input  read, write_en, grant, ack, err, busy
   );

   modport slave (
      input  req, src_sel, dst_sel,
      output read, write_en, grant, ack, err, busy
   );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational requester selector for the bus arbiter.
//   req    : request vector
//   rr_ptr : index of the last granted requester
//   winner : one-hot selected requester
//   index  : binary index of winner
//   any    : at least one request present
// Default: round-robin, search starts at rr_ptr+1 and wraps.
// With BUS_ARB_PRIORITY_EN defined: fixed priority, lowest index wins
// and rr_ptr is ignored.
module bus_arbiter_rr_picker #(
   parameter int NREQ  = 2,
   parameter int PTR_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [NREQ-1:0]  winner,
   output logic [PTR_W-1:0] index,
   output logic             any
);

`ifdef BUS_ARB_PRIORITY_EN
   logic unused_ptr;
   assign unused_ptr = ^rr_ptr;

   always_comb begin
      logic found;
      winner = '0;
      index  = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req[i] && !found) begin
            found     = 1'b1;
            winner[i] = 1'b1;
            index     = PTR_W'(i);
         end
      end
      any = found;
   end
`else
   always_comb begin
      logic        found;
      int unsigned cand;
      winner = '0;
      index  = '0;
      found  = 1'b0;
      cand   = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = (int'(rr_ptr) + k) % NREQ;
         if (req[cand] && !found) begin
            found        = 1'b1;
            winner[cand] = 1'b1;
            index        = PTR_W'(cand);
         end
      end
      any = found;
   end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Register-transfer bus arbiter: grants the bus to one of NREQ requesters,
// drives the bus read select, waits DM_WAIT extra cycles for data memory,
// then pulses a one-hot destination write enable together with ack.
//   clock   : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : bus_arbiter_if.slave (req/src_sel/dst_sel in,
//             read/write_en/grant/ack/err/busy out)
// Parameters: NREQ (2..4), NDST destinations, DM_WAIT settle cycles for src 2.
// Optional macro BUS_ARB_PRIORITY_EN selects fixed priority instead of
// round-robin.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int NDST    = 16,
   parameter int DM_WAIT = 1
) (
   input  logic          clock,
   input  logic          reset_n,
   bus_arbiter_if.slave  bus
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = (DM_WAIT > 1) ? $clog2(DM_WAIT) : 1;
   localparam logic [SEL_W-1:0] DST_MAX = SEL_W'(NDST);

   state_t           state;
   logic [PTR_W-1:0] rr_ptr;
   logic [CNT_W-1:0] cnt;
   logic [SEL_W-1:0] src_q;
   logic [SEL_W-1:0] dst_q;
   logic             legal_q;

   logic [NREQ-1:0]  win_oh;
   logic [PTR_W-1:0] win_idx;
   logic             win_any;
   logic [SEL_W-1:0] win_src;
   logic [SEL_W-1:0] win_dst;
   logic             win_legal;
   logic [NDST-1:0]  wr_strobe;

   bus_arbiter_rr_picker #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req    (bus.req),
      .rr_ptr (rr_ptr),
      .winner (win_oh),
      .index  (win_idx),
      .any    (win_any)
   );

   always_comb begin
      win_src = '0;
      win_dst = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win_oh[i]) begin
            win_src = bus.src_sel[i*SEL_W +: SEL_W];
            win_dst = bus.dst_sel[i*SEL_W +: SEL_W];
         end
      end
      win_legal = transfer_legal(win_src, win_dst, DST_MAX);
   end

   always_comb begin
      wr_strobe = '0;
      if (legal_q) begin
         wr_strobe = NDST'(1) << (dst_q - 5'd1);
      end
   end

   // Outputs are registered for the state being entered, so the strobes
   // for WRITE are loaded on the transition out of SRC or WAIT.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         rr_ptr       <= PTR_W'(NREQ - 1);
         cnt          <= '0;
         src_q        <= '0;
         dst_q        <= '0;
         legal_q      <= 1'b0;
         bus.read     <= '0;
         bus.write_en <= '0;
         bus.grant    <= '0;
         bus.ack      <= '0;
         bus.err      <= 1'b0;
         bus.busy     <= 1'b0;
      end else begin
         bus.write_en <= '0;
         bus.ack      <= '0;
         bus.err      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (win_any) begin
                  src_q     <= win_src;
                  dst_q     <= win_dst;
                  legal_q   <= win_legal;
                  rr_ptr    <= win_idx;
                  bus.grant <= win_oh;
                  bus.busy  <= 1'b1;
                  bus.read  <= win_legal ? win_src : SRC_NONE;
                  state     <= ST_SRC;
               end
            end
            ST_SRC: begin
               if ((src_q == SRC_DM) && (DM_WAIT > 0)) begin
                  cnt   <= CNT_W'(DM_WAIT - 1);
                  state <= ST_WAIT;
               end else begin
                  bus.write_en <= wr_strobe;
                  bus.ack      <= bus.grant;
                  bus.err      <= !legal_q;
                  state        <= ST_WRITE;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  bus.write_en <= wr_strobe;
                  bus.ack      <= bus.grant;
                  bus.err      <= !legal_q;
                  state        <= ST_WRITE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_WRITE: begin
               bus.grant <= '0;
               bus.busy  <= 1'b0;
               bus.read  <= SRC_NONE;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
